// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: DEPTH-word program store with per-word programmed bits and a fixed-latency fetch pipe.
// Latency: a fetch accepted at edge N is presented on Resp* in the cycle sampled by edge N+LATENCY.
// Backpressure: none on responses; ReqReady drops combinationally while LoadEn or Reset is high.
//
// Ports:
//   CLK, Reset                      - clock, synchronous active-high reset
//   LoadEn, LoadAddr, LoadData      - program-load write port (byte address, word aligned only)
//   ReqValid, ReqAddr, ReqReady     - fetch request handshake
//   RespValid, RespData, RespAddr,  - fetch response; RespFault: 00 ok, 01 misaligned,
//   RespFault                         10 out of range, 11 unprogrammed
module instr_fetch_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    input  logic              ReqValid,
    input  logic [ADDR_W-1:0] ReqAddr,
    output logic              ReqReady,
    output logic              RespValid,
    output logic [DATA_W-1:0] RespData,
    output logic [ADDR_W-1:0] RespAddr,
    output logic [1:0]        RespFault
);

    localparam int IDX_W = $clog2(DEPTH);
    // First byte address past the store; compared against the full address so
    // high address bits can never alias onto a valid word.
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * DEPTH);

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;
    localparam logic [1:0] FLT_UNPRG = 2'b11;

    typedef struct packed {
        logic              vld;
        logic [1:0]        fault;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  prog_q;
    stage_t            pipe_q [LATENCY];
    stage_t            stage_d;

    logic              load_ok;
    logic [IDX_W-1:0]  load_idx;
    logic [IDX_W-1:0]  req_idx;
    logic              accept;

    assign load_idx = LoadAddr[IDX_W+1:2];
    assign req_idx  = ReqAddr[IDX_W+1:2];

    // Loads outside the store or not word aligned are dropped without effect.
    assign load_ok  = LoadEn && !Reset && (LoadAddr[1:0] == 2'b00) && (LoadAddr < LIMIT);

    assign ReqReady = !LoadEn && !Reset;
    assign accept   = ReqValid && ReqReady;

    // Program store has no reset: only the programmed bits are cleared.
    always_ff @(posedge CLK) begin
        if (load_ok) begin
            mem_q[load_idx] <= LoadData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            prog_q <= '0;
        end else if (load_ok) begin
            prog_q[load_idx] <= 1'b1;
        end
    end

    // Storage is read in the accept cycle so later loads cannot alter a
    // response already in flight. Idle slots carry all-zero contents, which
    // makes the pipe output directly usable as the zeroed idle response.
    always_comb begin
        stage_d = '0;
        if (accept) begin
            stage_d.vld  = 1'b1;
            stage_d.addr = ReqAddr;
            if (ReqAddr[1:0] != 2'b00) begin
                stage_d.fault = FLT_ALIGN;
            end else if (ReqAddr >= LIMIT) begin
                stage_d.fault = FLT_RANGE;
            end else if (!prog_q[req_idx]) begin
                stage_d.fault = FLT_UNPRG;
            end else begin
                stage_d.fault = FLT_OK;
                stage_d.data  = mem_q[req_idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign RespValid = pipe_q[LATENCY-1].vld;
    assign RespData  = pipe_q[LATENCY-1].data;
    assign RespAddr  = pipe_q[LATENCY-1].addr;
    assign RespFault = pipe_q[LATENCY-1].fault;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: four configurations (DEPTH/LATENCY mixes) share one stimulus stream.
// Each configuration keeps its own reference store and expected-response queue; a monitor per
// configuration checks every cycle for either the due response or an all-zero idle output.
module tb_instr_fetch_mem;

    localparam int CW = 99;  // {valid, fault, addr, data}

    typedef struct {
        int          due;
        logic [63:0] addr;
        logic [31:0] data;
        logic [1:0]  fault;
    } exp_t;

    function automatic int dep_of(int i);
        case (i)
            0:       return 64;
            1:       return 16;
            2:       return 16;
            default: return 1024;
        endcase
    endfunction

    function automatic int lat_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        Reset;
    logic        LoadEn;
    logic [63:0] LoadAddr;
    logic [31:0] LoadData;
    logic        ReqValid;
    logic [63:0] ReqAddr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : gen_cfg
        localparam int D = dep_of(g);
        localparam int L = lat_of(g);

        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic [63:0] ra;
        logic [1:0]  rf;

        instr_fetch_mem #(
            .DATA_W (32),
            .ADDR_W (64),
            .DEPTH  (D),
            .LATENCY(L)
        ) u_dut (
            .CLK      (clk),
            .Reset    (Reset),
            .LoadEn   (LoadEn),
            .LoadAddr (LoadAddr),
            .LoadData (LoadData),
            .ReqValid (ReqValid),
            .ReqAddr  (ReqAddr),
            .ReqReady (rdy),
            .RespValid(rv),
            .RespData (rd),
            .RespAddr (ra),
            .RespFault(rf)
        );

        logic [31:0] mem_m [D];
        bit          prog_m [D];
        exp_t        q [$];
        int          edge_n = 0;

        // Reference model: behaviour stated as address arithmetic on a word array.
        initial begin
            exp_t e;
            forever begin
                @(posedge clk);
                edge_n++;
                if (Reset) begin
                    q.delete();
                    for (int k = 0; k < D; k++) prog_m[k] = 1'b0;
                end else if (LoadEn) begin
                    if (LoadAddr % 4 == 0 && LoadAddr < 64'(4 * D)) begin
                        mem_m[int'(LoadAddr / 4)]  = LoadData;
                        prog_m[int'(LoadAddr / 4)] = 1'b1;
                    end
                end else if (ReqValid) begin
                    e.due  = edge_n + L;
                    e.addr = ReqAddr;
                    e.data = '0;
                    if (ReqAddr % 4 != 0)              e.fault = 2'b01;
                    else if (ReqAddr >= 64'(4 * D))    e.fault = 2'b10;
                    else if (!prog_m[int'(ReqAddr / 4)]) e.fault = 2'b11;
                    else begin
                        e.fault = 2'b00;
                        e.data  = mem_m[int'(ReqAddr / 4)];
                    end
                    q.push_back(e);
                end
            end
        end

        // Monitor: outputs visible after edge M are those sampled at edge M+1.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                chk($sformatf("cfg%0d.ready", g), CW'(rdy), CW'(!LoadEn && !Reset));
                if (q.size() > 0 && q[0].due <= edge_n + 1) begin
                    e = q.pop_front();
                    chk($sformatf("cfg%0d.resp@%0d", g, edge_n), {rv, rf, ra, rd},
                        {1'b1, e.fault, e.addr, e.data});
                end else begin
                    chk($sformatf("cfg%0d.idle@%0d", g, edge_n), {rv, rf, ra, rd}, '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        LoadEn   = 1'b1;
        LoadAddr = a;
        LoadData = d;
        tick();
        LoadEn   = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a);
        ReqValid = 1'b1;
        ReqAddr  = a;
        tick();
        ReqValid = 1'b0;
    endtask

    function automatic logic [63:0] bnd_addr(int i);
        case (i)
            0:       return 64'd60;
            1:       return 64'd64;
            2:       return 64'd252;
            3:       return 64'd256;
            4:       return 64'd4092;
            default: return 64'd4096;
        endcase
    endfunction

    function automatic logic [63:0] rnd_addr();
        int unsigned s;
        logic [63:0] a;
        s = $urandom_range(0, 9);
        case (s)
            0:       a = 64'($urandom_range(0, 255));
            1:       a = 64'h1_0000_0000 + 64'($urandom_range(0, 15) * 4);
            2:       a = bnd_addr(int'($urandom_range(0, 5)));
            3, 4, 5: a = 64'($urandom_range(0, 15) * 4);
            default: a = 64'($urandom_range(0, 1024) * 4);
        endcase
        return a;
    endfunction

    initial begin
        Reset    = 1'b1;
        LoadEn   = 1'b0;
        LoadAddr = '0;
        LoadData = '0;
        ReqValid = 1'b0;
        ReqAddr  = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Basic load then fetch.
        load(64'h0, 32'hF84003E9);
        fetch(64'h0);
        repeat (5) tick();

        // Unprogrammed, misaligned, out of range.
        fetch(64'h4);
        fetch(64'h6);
        fetch(64'h100);
        repeat (5) tick();

        // Back-to-back fetches.
        load(64'h4, 32'h1111_2222);
        load(64'h8, 32'h3333_4444);
        fetch(64'h0);
        fetch(64'h4);
        fetch(64'h8);
        repeat (5) tick();

        // Load concurrent with a request stalls it by one cycle.
        LoadEn   = 1'b1;
        LoadAddr = 64'hC;
        LoadData = 32'hCAFE_0001;
        ReqValid = 1'b1;
        ReqAddr  = 64'hC;
        tick();
        LoadEn = 1'b0;
        tick();
        ReqValid = 1'b0;
        repeat (5) tick();

        // Range boundaries for every depth.
        for (int i = 0; i < 6; i++) load(bnd_addr(i), 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 6; i++) fetch(bnd_addr(i));
        fetch(64'h1_0000_0000);
        fetch(64'h8000_0000_0000_0004);
        repeat (6) tick();

        // A later load to the same word leaves the in-flight response untouched.
        fetch(64'h0);
        load(64'h0, 32'hDEAD_BEEF);
        fetch(64'h0);
        repeat (6) tick();

        // Reset one cycle after accept flushes the pipe and the programmed bits.
        load(64'h10, 32'h5A5A_A5A5);
        fetch(64'h10);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        repeat (6) tick();
        fetch(64'h10);
        repeat (6) tick();

        // Randomised traffic, including occasional mid-stream resets.
        for (int c = 0; c < 600; c++) begin
            Reset    = ($urandom_range(0, 99) < 2);
            LoadEn   = ($urandom_range(0, 3) == 0);
            LoadAddr = rnd_addr();
            LoadData = $urandom;
            ReqValid = ($urandom_range(0, 3) != 0);
            ReqAddr  = rnd_addr();
            tick();
        end
        Reset    = 1'b0;
        LoadEn   = 1'b0;
        ReqValid = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64, number of instruction words; power of two, 2..1024.
REQ-004 SHALL have parameter LATENCY, default 2, accept-to-response cycles; legal range 1..4.
REQ-005 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-007 SHALL have port LoadEn, input, 1, program-load write strobe.
REQ-008 SHALL have port LoadAddr, input, ADDR_W, byte address of the word being loaded.
REQ-009 SHALL have port LoadData, input, DATA_W, instruction word being loaded.
REQ-010 SHALL have port ReqValid, input, 1, fetch request present.
REQ-011 SHALL have port ReqAddr, input, ADDR_W, fetch byte address.
REQ-012 SHALL have port ReqReady, output, 1, fetch request can be accepted this cycle.
REQ-013 SHALL have port RespValid, output, 1, response valid this cycle.
REQ-014 SHALL have port RespData, output, DATA_W, fetched instruction word.
REQ-015 SHALL have port RespAddr, output, ADDR_W, echo of the accepted ReqAddr.
REQ-016 SHALL have port RespFault, output, 2, 00 ok, 01 misaligned, 10 out of range, 11 unprogrammed.

Function
REQ-017 SHALL hold DEPTH words of storage plus one programmed bit per word; word index = addr[log2(DEPTH)+1:2].
REQ-018 SHALL write LoadData at LoadEn=1 when LoadAddr[1:0]=00 and LoadAddr < 4*DEPTH, and set that word's programmed bit; other loads are silently dropped.
REQ-019 SHALL drive ReqReady = !LoadEn && !Reset; loads take priority and stall fetch combinationally.
REQ-020 SHALL accept a fetch when ReqValid && ReqReady; one accept per cycle, fully pipelined, no response backpressure.
REQ-021 SHALL present the response for a request accepted at edge N at RespValid=1 exactly LATENCY edges later (N+LATENCY), in acceptance order.
REQ-022 SHALL sample storage at the accept edge; a load to the same word in a later cycle does not alter an in-flight response.
REQ-023 SHALL classify faults in priority order: misaligned (addr[1:0]!=00) > out of range (addr >= 4*DEPTH, full ADDR_W compare) > unprogrammed > ok.
REQ-024 SHALL drive RespData = 0 when RespFault != 00, and the stored word otherwise.
REQ-025 SHALL drive RespValid=0, RespData=0, RespAddr=0, RespFault=00 in every cycle with no response due.
REQ-026 SHALL not wrap addresses; an address equal to 4*DEPTH or above faults even if its low bits index a valid word.

Reset
REQ-027 SHALL on Reset clear all programmed bits, flush every pipeline stage, and force RespValid, RespData, RespAddr, RespFault to 0 from the edge Reset is sampled.
REQ-028 SHALL discard requests in flight at a mid-operation reset; none produce a response after Reset deasserts.
REQ-029 SHALL ignore LoadEn while Reset is high; storage contents need not be cleared.

Verification
REQ-030 Reset, load 0xF84003E9 at 0x0, fetch 0x0 (LATENCY=2) -> two edges later RespValid=1, RespData=0xF84003E9, RespFault=00.
REQ-031 Fetch 0x4 never loaded after reset -> RespFault=11, RespData=0; fetch 0x6 -> RespFault=01; fetch 0x100 with DEPTH=64 -> RespFault=10.
REQ-032 Back-to-back fetches 0x0,0x4,0x8 on consecutive cycles -> three consecutive responses in order, RespAddr 0x0,0x4,0x8.
REQ-033 LoadEn=1 concurrent with ReqValid=1 -> ReqReady=0, no response issued for that cycle; request accepted the cycle after LoadEn drops.
REQ-034 Reset asserted one cycle after accept with LATENCY=3 -> no RespValid in any later cycle; previously loaded address now reads RespFault=11.
REQ-035 Sweep LATENCY 1..4 and DEPTH 16 and 1024 -> response timing per REQ-021 and range fault boundary at 4*DEPTH-4 (ok) / 4*DEPTH (fault).
